shift_register_128to32: RTL and testbench
=========================================

// Module: shift_register_128to32
// PURPOSE
// - Parallel-in/serial-out word buffer: captures one 128-bit block (e.g. AES state or ciphertext)
//   and presents it as four 32-bit words, one word advanced per shift request.
// - Sits between the 128-bit AES datapath and a 32-bit bus/interface.
// PARAMETERS
// - DATA_W  32  output word width in bits
// - WORDS   4   words per block; input width = DATA_W*WORDS (128 at defaults)
// PORTS
// - clk         in   1        rising-edge clock; single clock domain
// - reset       in   1        synchronous, active-high reset
// - data_in     in   128      block to capture
// - load        in   1        capture data_in on this clock edge
// - shift_out   in   1        advance to next word on this clock edge
// - data_out    out  32       current head word
// - out_valid   out  1        data_out holds an unconsumed word (words_left != 0)
// - empty       out  1        all words consumed (words_left == 0)
// - words_left  out  3        unconsumed words remaining, 0..4
// BEHAVIOUR
// - Single clock, clk; reset is synchronous and active-high.
// - Reset: 128-bit buffer = 0, words_left = 0, so data_out = 0, out_valid = 0, empty = 1.
// - Reset has priority over load and shift_out.
// - Default order is most-significant word first: data_out = buf[127:96].
// - data_out is a combinational slice of the registered buffer; no extra output register.
// - load = 1: buf <= data_in, words_left <= 4.
//   - First word appears on data_out in the cycle after the load edge (latency 1).
// - shift_out = 1, load = 0, words_left != 0: buf <= buf << 32 (zero fill), words_left decrements.
// - shift_out while empty: ignored; buffer and count do not change, no underflow.
// - After the 4th shift: data_out = 0, words_left = 0, empty = 1.
// - load and shift_out asserted together: load wins; the block restarts at word 0, shift is dropped.
// - load while words remain: the old block is discarded and overwritten.
// - shift_out held high: one word per cycle, then remains empty until the next load.
// - Inputs never go X-propagating into state: an unasserted (0) control means hold.
// CONFIGURATION
// - SR128_LSW_FIRST_EN defined:
//   - Least-significant word goes out first: data_out = buf[31:0].
//   - Shift is buf >> 32 with zero fill into the top word.
//   - Counts, flags, priorities and latency are identical to default mode.
// - SR128_LSW_FIRST_EN undefined (default): MSW-first order as described above.
// TESTING
// - Reset held 1 cycle -> data_out = 0, out_valid = 0, empty = 1, words_left = 0.
// - Load 0x0123456789ABCDEF0123456789ABCDEF, then shift_out held high ->
//   data_out = 01234567, 89ABCDEF, 01234567, 89ABCDEF, then 00000000 with empty = 1.
// - Shift 3 more cycles while empty -> no change; words_left stays 0.
// - Load A, 2 shifts, then load + shift same cycle with B = 0xFFEEDDCC_BBAA9988_77665544_33221100 ->
//   data_out = FFEEDDCC, words_left = 4.
// - Reset asserted mid-stream (words_left = 2) -> next cycle data_out = 0 and empty = 1;
//   a subsequent shift still produces 0.
// - With SR128_LSW_FIRST_EN: load B and shift 4 times ->
//   data_out = 33221100, 77665544, BBAA9988, FFEEDDCC, then 0.

Source files
------------

// File: rtl/shift_register_128to32.sv
// shift_register_128to32
// Parallel-in / serial-out word buffer: captures one DATA_W*WORDS block and
// presents it one DATA_W word at a time, advancing one word per shift request.
// Sits between the 128-bit AES datapath and a 32-bit bus.
//
// Build option:
//   SR128_LSW_FIRST_EN  defined   -> least-significant word first, shift right
//                       undefined -> most-significant word first, shift left
//
// The block is held as WORDS independent word lanes. Each lane either captures
// its slice of data_in, takes its neighbour's word on a shift (zero fill at the
// far end), or holds. data_out is a combinational pick of the head lane.

// One word lane of the buffer.
module shift_register_128to32_lane #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] load_word,
   input  logic [DATA_W-1:0] next_word,
   output logic [DATA_W-1:0] word
);

   // Reset clears, load captures, shift takes the neighbour word, else hold.
   always_ff @(posedge clk) begin
      if (reset)
         word <= '0;
      else if (load)
         word <= load_word;
      else if (shift)
         word <= next_word;
   end

endmodule

module shift_register_128to32 #(
   parameter int DATA_W = 32,
   parameter int WORDS  = 4,
   parameter int CNT_W  = $clog2(WORDS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W*WORDS-1:0]   data_in,
   input  logic                      load,
   input  logic                      shift_out,
   output logic [DATA_W-1:0]         data_out,
   output logic                      out_valid,
   output logic                      empty,
   output logic [CNT_W-1:0]          words_left
);

   // Word view of the block; index 0 is the least-significant word.
   logic [WORDS-1:0][DATA_W-1:0] blk;
   logic [WORDS-1:0][DATA_W-1:0] blk_in;
   logic [WORDS-1:0][DATA_W-1:0] nxt;
   logic                         shift_en;

   assign blk_in = data_in;

   // Load wins over shift; a shift with nothing left is dropped so the
   // buffer and count never underflow.
   assign shift_en = shift_out & ~load & (words_left != '0);

   genvar i;
   generate
      for (i = 0; i < WORDS; i++) begin : g_lane
`ifdef SR128_LSW_FIRST_EN
         // Shift right: each lane takes the next-higher word, top fills with 0.
         if (i == WORDS - 1) begin : g_edge
            assign nxt[i] = '0;
         end else begin : g_mid
            assign nxt[i] = blk[i+1];
         end
`else
         // Shift left: each lane takes the next-lower word, bottom fills with 0.
         if (i == 0) begin : g_edge
            assign nxt[i] = '0;
         end else begin : g_mid
            assign nxt[i] = blk[i-1];
         end
`endif
         shift_register_128to32_lane #(
            .DATA_W (DATA_W)
         ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .shift     (shift_en),
            .load_word (blk_in[i]),
            .next_word (nxt[i]),
            .word      (blk[i])
         );
      end
   endgenerate

`ifdef SR128_LSW_FIRST_EN
   assign data_out = blk[0];
`else
   assign data_out = blk[WORDS-1];
`endif

   // Remaining-word counter: full on load, one less per accepted shift.
   always_ff @(posedge clk) begin
      if (reset)
         words_left <= '0;
      else if (load)
         words_left <= CNT_W'(WORDS);
      else if (shift_en)
         words_left <= words_left - 1'b1;
   end

   assign out_valid = (words_left != '0);
   assign empty     = (words_left == '0);

endmodule

// File: tb/tb_shift_register_128to32.sv
// Scoreboard bench for shift_register_128to32: the stimulus process drives one
// clock of control per step and queues the hand-computed expected outputs; a
// monitor on the falling edge pops and compares whenever an entry is pending.
// Build with SR128_LSW_FIRST_EN defined to exercise least-word-first order.
module tb_shift_register_128to32;

   logic         clk;
   logic         reset;
   logic [127:0] data_in;
   logic         load;
   logic         shift_out;
   logic [31:0]  data_out;
   logic         out_valid;
   logic         empty;
   logic [2:0]   words_left;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  wl;
      logic        vld;
      logic        emp;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [127:0] BLK_A = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] BLK_B = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

   // Expected head words in presentation order.
`ifdef SR128_LSW_FIRST_EN
   localparam logic [31:0] A0 = 32'h89ABCDEF, A1 = 32'h01234567,
                           A2 = 32'h89ABCDEF, A3 = 32'h01234567;
   localparam logic [31:0] B0 = 32'h33221100, B1 = 32'h77665544,
                           B2 = 32'hBBAA9988, B3 = 32'hFFEEDDCC;
`else
   localparam logic [31:0] A0 = 32'h01234567, A1 = 32'h89ABCDEF,
                           A2 = 32'h01234567, A3 = 32'h89ABCDEF;
   localparam logic [31:0] B0 = 32'hFFEEDDCC, B1 = 32'hBBAA9988,
                           B2 = 32'h77665544, B3 = 32'h33221100;
`endif

   shift_register_128to32 dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .load       (load),
      .shift_out  (shift_out),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .empty      (empty),
      .words_left (words_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one clock of control, then queue what the outputs must show.
   task automatic step(input logic r, input logic ld, input logic sh,
                       input logic [127:0] din, input logic [31:0] ed,
                       input logic [2:0] ewl, input logic ev, input logic ee,
                       input string nm);
      exp_t e;
      reset     = r;
      load      = ld;
      shift_out = sh;
      data_in   = din;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      load      = 1'b0;
      shift_out = 1'b0;
      e.data = ed; e.wl = ewl; e.vld = ev; e.emp = ee; e.name = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: compare on the falling edge whenever an expectation is pending.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (data_out !== e.data || words_left !== e.wl ||
             out_valid !== e.vld || empty !== e.emp) begin
            n_bad++;
            $display("FAIL %s: got data=%h wl=%0d vld=%b emp=%b, want data=%h wl=%0d vld=%b emp=%b",
                     e.name, data_out, words_left, out_valid, empty,
                     e.data, e.wl, e.vld, e.emp);
         end
      end
   end

   initial begin
      reset = 1'b1; load = 1'b0; shift_out = 1'b0; data_in = '0;

      step(1, 0, 0, '0,    32'h0, 3'd0, 0, 1, "reset");
      step(0, 0, 0, '0,    32'h0, 3'd0, 0, 1, "idle_after_reset");

      // Load A, then shift held high through the whole block.
      step(0, 1, 0, BLK_A, A0, 3'd4, 1, 0, "load_a");
      step(0, 0, 1, '0,    A1, 3'd3, 1, 0, "a_shift1");
      step(0, 0, 1, '0,    A2, 3'd2, 1, 0, "a_shift2");
      step(0, 0, 1, '0,    A3, 3'd1, 1, 0, "a_shift3");
      step(0, 0, 1, '0,    32'h0, 3'd0, 0, 1, "a_shift4_empty");

      // Shifting while empty changes nothing.
      step(0, 0, 1, '0,    32'h0, 3'd0, 0, 1, "empty_shift1");
      step(0, 0, 1, '0,    32'h0, 3'd0, 0, 1, "empty_shift2");
      step(0, 0, 1, '0,    32'h0, 3'd0, 0, 1, "empty_shift3");

      // Load A, two shifts, hold, then load+shift together with B.
      step(0, 1, 0, BLK_A, A0, 3'd4, 1, 0, "reload_a");
      step(0, 0, 1, '0,    A1, 3'd3, 1, 0, "ra_shift1");
      step(0, 0, 1, '0,    A2, 3'd2, 1, 0, "ra_shift2");
      step(0, 0, 0, '0,    A2, 3'd2, 1, 0, "ra_hold");
      step(0, 1, 1, BLK_B, B0, 3'd4, 1, 0, "load_shift_b");
      step(0, 0, 1, '0,    B1, 3'd3, 1, 0, "b_shift1");
      step(0, 0, 1, '0,    B2, 3'd2, 1, 0, "b_shift2");

      // Reset mid-stream wins over a concurrent shift; later shifts give 0.
      step(1, 0, 1, '0,    32'h0, 3'd0, 0, 1, "reset_midstream");
      step(0, 0, 1, '0,    32'h0, 3'd0, 0, 1, "shift_after_reset");

      // Reset beats load.
      step(1, 1, 0, BLK_B, 32'h0, 3'd0, 0, 1, "reset_over_load");

      // Full B block in presentation order.
      step(0, 1, 0, BLK_B, B0, 3'd4, 1, 0, "load_b");
      step(0, 0, 1, '0,    B1, 3'd3, 1, 0, "b2_shift1");
      step(0, 0, 1, '0,    B2, 3'd2, 1, 0, "b2_shift2");
      step(0, 0, 1, '0,    B3, 3'd1, 1, 0, "b2_shift3");
      step(0, 0, 1, '0,    32'h0, 3'd0, 0, 1, "b2_shift4_empty");

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
